// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - width helpers and explicit pointer wrap for fifo_level
package fifo_pkg;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap at depth-1 so non-power-of-2 depths never index past the array
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH storage, sync write, async read
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AW         = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - FWFT FIFO with occupancy, almost flags, flush and high-water mark
module fifo_level
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    parameter  int AF_THR     = 3,
    parameter  int AE_THR     = 1,
    localparam int CW         = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  push_grant_o,
    output logic                  pop_valid_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    input  logic                  pop_grant_i,
    input  logic                  flush_i,
    output logic [CW-1:0]         count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CW-1:0]         max_level_o
);

    localparam int          AW      = addr_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THR);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THR);

    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic [CW-1:0] count_q, count_next, max_q, max_next;
    logic          af_q, ae_q;
    logic          do_push, do_pop;

    // Grant looks only at the registered count: no combinational path from pop_grant_i
    assign push_grant_o = (count_q != FULL_CNT);
    assign pop_valid_o  = (count_q != '0);
    assign do_push      = push_valid_i && push_grant_o;
    assign do_pop       = pop_grant_i && pop_valid_o;

    assign rd_ptr_next = AW'(next_ptr(32'(rd_ptr), DEPTH));
    assign wr_ptr_next = AW'(next_ptr(32'(wr_ptr), DEPTH));

    always_comb begin
        count_next = count_q;
        if (do_push && !do_pop) begin
            count_next = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count_q - 1'b1;
        end
        max_next = (count_next > max_q) ? count_next : max_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            max_q   <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            max_q   <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr_next;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_next;
            end
            count_q <= count_next;
            max_q   <= max_next;
            af_q    <= (count_next >= AF_CNT);
            ae_q    <= (count_next <= AE_CNT);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_push && !flush_i),
        .wr_addr (wr_ptr),
        .wr_data (push_data_i),
        .rd_addr (rd_ptr),
        .rd_data (pop_data_o)
    );

    assign count_o        = count_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign max_level_o    = max_q;

endmodule
